mem_access_stage: RTL

- Pipeline stage directly downstream of the ALU.
- Consumes the ALU result plus opcode, performs the data-memory access for load (op 35) and store (op 43), and passes every other result through unchanged.
- Single-entry buffered stage with valid/ready handshakes on the ALU side and the writeback side, and a req/ack handshake to data memory with a timeout.
- Flags misaligned or timed-out accesses to writeback as errors.

---
 rtl/mem_access_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: buffers one ALU result, performs the data-memory
// load/store over a req/ack port with a timeout, and presents the result to writeback.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_op_code,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_we,
  output logic              wb_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [5:0] OP_LOAD  = 6'd35;
  localparam logic [5:0] OP_STORE = 6'd43;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_err_q, wb_err_d;

  logic accept;
  logic is_mem;
  logic is_branch;
  logic aligned;

  // Handshakes: an ALU entry transfers on a cycle where ex_valid && ex_ready; a
  // writeback entry transfers where wb_valid && wb_ready. wb_* are held stable
  // while wb_valid && !wb_ready; mem_* are held stable while mem_req is high.
  assign ex_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && wb_ready);
  assign accept    = ex_valid && ex_ready;
  assign is_mem    = (ex_op_code == OP_LOAD) || (ex_op_code == OP_STORE);
  assign is_branch = (ex_op_code == 6'd41) || ((ex_op_code >= 6'd48) && (ex_op_code <= 6'd54));
  assign aligned   = (ex_alu_result[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_err_d    = wb_err_q;

    case (state_q)
      ST_IDLE: ;
      ST_ACCESS: begin
        // An ack in the expiry cycle still completes the access normally.
        if (mem_ack) begin
          state_d  = ST_HOLD;
          wb_err_d = 1'b0;
          if (mem_we_q) begin
            wb_we_d = 1'b0;
          end else begin
            wb_we_d   = 1'b1;
            wb_data_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HOLD;
          wb_err_d = 1'b1;
          wb_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      wb_rd_d   = ex_rd;
      wb_err_d  = 1'b0;
      wb_data_d = ex_alu_result;
      cnt_d     = 8'd0;
      if (is_mem && aligned) begin
        state_d     = ST_ACCESS;
        wb_we_d     = 1'b0;
        mem_we_d    = (ex_op_code == OP_STORE);
        mem_addr_d  = ex_alu_result[ADDR_W-1:0];
        mem_wdata_d = ex_store_data;
      end else begin
        state_d = ST_HOLD;
        if (is_mem) begin
          wb_err_d = 1'b1;
          wb_we_d  = 1'b0;
        end else begin
          wb_we_d = !is_branch;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = (state_q == ST_HOLD);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_we     = wb_we_q;
  assign wb_err    = wb_err_q;
  assign dbg_state = state_q;

endmodule
